exmem_stage: RTL and testbench
==============================

# exmem_stage

EX/MEM pipeline register plus data-memory access control for the 5-stage MIPS pipeline, sitting directly downstream of the ID/EX latch and EX stage. It captures EX results into an M slot, drives the data-cache request for loads and stores, stalls the front of the pipeline until `dhit`, and forwards completed instructions into a registered MEM/WB slot (W). A sticky halt state freezes the block once a halt instruction reaches W.

## Interface
- `WORD_W`, 32, data, address and PC width
- `REG_W`, 5, register-select width
- `CLK`  in  1  pipeline clock; all state updates on the rising edge
- `nRST`  in  1  reset; one clock, synchronous, active-low
- `flush`  in  1  insert a bubble into M instead of the EX result (branch/jump squash)
- `aluout_i`  in  WORD_W  EX ALU result; memory address for loads and stores
- `rdat2_i`  in  WORD_W  store data (forwarded rt value)
- `npc_i`  in  WORD_W  PC+4 of the instruction (for JAL writeback)
- `wsel_i`  in  REG_W  destination register
- `RegW_i`, `MemToReg_i`, `DRen_i`, `DWen_i`, `halt_i`  in  1 each  EX control bits
- `dhit`  in  1  dcache access complete this cycle
- `dload`  in  WORD_W  dcache read data, valid when `dhit`
- `dREN`, `dWEN`  out  1  dcache read/write request
- `daddr`, `dstore`  out  WORD_W  dcache address and store data
- `mem_stall`  out  1  freeze IF/ID, ID/EX and EX inputs this cycle
- `aluout_o`, `dload_o`, `npc_o`  out  WORD_W  W-slot data
- `wsel_o`  out  REG_W  W-slot destination register
- `RegW_o`, `MemToReg_o`, `halt_o`  out  1  W-slot controls

## Operation
- FSM states: RUN, WAIT, HALTED.
- Reset (`nRST`=0 at edge): M and W cleared to bubbles (all data 0, all controls 0); state RUN. Every output then reads 0, including `dREN`, `dWEN`, `mem_stall` and `halt_o`.
- M slot is a memory op when `DRen`|`DWen` is latched in it. While M holds a memory op and state is RUN or WAIT, `dREN`/`dWEN` equal the M bits. `daddr`=M.aluout and `dstore`=M.rdat2; both are combinational from M and stable for the whole request.
- `mem_stall` = M memory op & !`dhit` (combinational).
- RUN, no stall, rising edge:
  - M to W. If M was a load, `dload` is captured into W.dload.
  - Inputs to M, or a bubble if `flush`=1.
  - If the new M is a memory op, next state is WAIT. Otherwise the state stays RUN.
- WAIT: M holds and inputs are ignored, including `flush`; the hazard unit holds `flush` itself. W loads a bubble each stalled edge. On the `dhit` edge the transfer follows the RUN rules and the state returns to RUN, or stays WAIT if the newly latched M is also a memory op.
- A store completes on `dhit`. Its W copy carries `RegW`=0, which is forced if the input is inconsistent.
- `halt_o`=1 in W leads to HALTED on the next edge. HALTED:
  - M and W freeze.
  - `dREN`/`dWEN`/`mem_stall` are forced to 0.
  - `halt_o` stays 1.
  - The only exit is reset.
- Instructions behind the halt are never passed to W.
- `flush` and a non-stalled edge arriving together: the bubble wins and W still receives the old M.
- A reset edge during WAIT abandons the request: `dREN`/`dWEN` are 0 in the cycle after the edge.

## Timing
- Non-memory instruction: EX at cycle t, M at t+1, W outputs valid at t+2.
- Load or store with a hit in its first M cycle (t+1): no stall, W at t+2.
- Each cycle without `dhit` adds one cycle of `mem_stall` and one W bubble.
- `dREN`/`dWEN` assert in the same cycle the op enters M; there is no extra request cycle.
- W outputs change only on clock edges. `mem_stall`, `dREN`/`dWEN`, `daddr` and `dstore` are combinational from M and `dhit`.

## Test plan
- **Reset:** hold `nRST`=0 for 2 edges with random inputs. All outputs must be 0.
- **ALU op:** `aluout_i`=0x0000_0010, `wsel_i`=5, `RegW_i`=1, no memory. Two edges later `aluout_o`=0x10, `wsel_o`=5, `RegW_o`=1, and `mem_stall` never asserts.
- **Load with a 3-cycle miss:**
  - Stimulus: `DRen_i`=1, `aluout_i`=0x0000_0100, `MemToReg_i`=1, `wsel_i`=8; `dhit` goes high on the 3rd M cycle with `dload`=0xDEAD_BEEF.
  - Required: `dREN`=1 and `daddr`=0x100 for 3 cycles, and `mem_stall`=1 for 2 cycles. W shows 2 bubbles, then `dload_o`=0xDEAD_BEEF, `wsel_o`=8, `RegW_o`=1.
- **Store with an immediate hit:**
  - Stimulus: `DWen_i`=1, `rdat2_i`=0x1234_5678, `aluout_i`=0x200, `dhit`=1.
  - Required: `dWEN`=1 and `dstore`=0x1234_5678 for one cycle, no stall, and W `RegW_o`=0.
- **Flush and stall interaction:**
  - `flush`=1 during RUN: M becomes a bubble, and a following `RegW_o`=0 appears in W.
  - `flush`=1 during WAIT: M is unchanged and the request is still pending.
- **Halt and mid-access reset:**
  - `halt_i`=1 followed by a load: `halt_o`=1 sticks, and `dREN` never asserts for the trailing load.
  - Separately, pulse `nRST`=0 during WAIT: `dREN`=0 in the next cycle and state is RUN.

Source files
------------

// File: rtl/exmem_stage.sv
// exmem_stage
// EX/MEM pipeline register with data-memory access control and a registered
// MEM/WB slot. The M slot captures EX results, drives the dcache request while
// it holds a load or store, and stalls the front of the pipeline until dhit.
// Finished instructions move into the W slot. A halt reaching W freezes the
// block until reset.
//
// Ports
//   CLK, nRST              clock, synchronous active-low reset
//   flush                  squash: bubble into M instead of the EX result
//   aluout_i .. halt_i     EX-stage results and control bits
//   dhit, dload            dcache completion and read data
//   dREN, dWEN             dcache read/write request (combinational from M)
//   daddr, dstore          dcache address and store data (combinational from M)
//   mem_stall              freeze the front of the pipeline this cycle
//   aluout_o .. halt_o     registered W-slot outputs
module exmem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic [WORD_W-1:0] aluout_i,
  input  logic [WORD_W-1:0] rdat2_i,
  input  logic [WORD_W-1:0] npc_i,
  input  logic [REG_W-1:0]  wsel_i,
  input  logic              RegW_i,
  input  logic              MemToReg_i,
  input  logic              DRen_i,
  input  logic              DWen_i,
  input  logic              halt_i,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] aluout_o,
  output logic [WORD_W-1:0] dload_o,
  output logic [WORD_W-1:0] npc_o,
  output logic [REG_W-1:0]  wsel_o,
  output logic              RegW_o,
  output logic              MemToReg_o,
  output logic              halt_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // M slot
  logic [WORD_W-1:0] r_m_aluout, r_m_rdat2, r_m_npc;
  logic [REG_W-1:0]  r_m_wsel;
  logic              r_m_regw, r_m_memtoreg, r_m_dren, r_m_dwen, r_m_halt;

  // W slot
  logic [WORD_W-1:0] r_w_aluout, r_w_dload, r_w_npc;
  logic [REG_W-1:0]  r_w_wsel;
  logic              r_w_regw, r_w_memtoreg, r_w_halt;

  logic w_m_memop;
  logic w_advance;
  logic w_m_nxt_memop;
  logic w_take_input;

  assign w_m_memop = r_m_dren | r_m_dwen;

  // M moves to W only when running, its access (if any) is done, and no halt
  // has reached W. A halt sitting in W is the last instruction ever retired.
  assign w_advance = (r_state != ST_HALTED) & ~r_w_halt & ~mem_stall;

  // Anything behind a halt is squashed so it can never issue a dcache request.
  assign w_take_input  = ~flush & ~r_m_halt;
  assign w_m_nxt_memop = w_take_input & (DRen_i | DWen_i);

  assign daddr  = r_m_aluout;
  assign dstore = r_m_rdat2;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: WAIT whenever the slot entering M is a memory op
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN, ST_WAIT: begin
        if (r_w_halt) begin
          w_state_nxt = ST_HALTED;
        end else if (w_advance) begin
          w_state_nxt = w_m_nxt_memop ? ST_WAIT : ST_RUN;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // Output logic: dcache request and stall, all suppressed once halted
  always_comb begin
    dREN      = 1'b0;
    dWEN      = 1'b0;
    mem_stall = 1'b0;
    case (r_state)
      ST_RUN, ST_WAIT: begin
        dREN      = r_m_dren;
        dWEN      = r_m_dwen;
        mem_stall = w_m_memop & ~dhit;
      end
      ST_HALTED: begin
        dREN      = 1'b0;
        dWEN      = 1'b0;
        mem_stall = 1'b0;
      end
      default: begin
        dREN      = 1'b0;
        dWEN      = 1'b0;
        mem_stall = 1'b0;
      end
    endcase
  end

  // M slot: capture EX (or a bubble) on advance, otherwise hold
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_m_aluout   <= {WORD_W{1'b0}};
      r_m_rdat2    <= {WORD_W{1'b0}};
      r_m_npc      <= {WORD_W{1'b0}};
      r_m_wsel     <= {REG_W{1'b0}};
      r_m_regw     <= 1'b0;
      r_m_memtoreg <= 1'b0;
      r_m_dren     <= 1'b0;
      r_m_dwen     <= 1'b0;
      r_m_halt     <= 1'b0;
    end else if (w_advance) begin
      if (w_take_input) begin
        r_m_aluout   <= aluout_i;
        r_m_rdat2    <= rdat2_i;
        r_m_npc      <= npc_i;
        r_m_wsel     <= wsel_i;
        r_m_regw     <= RegW_i;
        r_m_memtoreg <= MemToReg_i;
        r_m_dren     <= DRen_i;
        r_m_dwen     <= DWen_i;
        r_m_halt     <= halt_i;
      end else begin
        r_m_aluout   <= {WORD_W{1'b0}};
        r_m_rdat2    <= {WORD_W{1'b0}};
        r_m_npc      <= {WORD_W{1'b0}};
        r_m_wsel     <= {REG_W{1'b0}};
        r_m_regw     <= 1'b0;
        r_m_memtoreg <= 1'b0;
        r_m_dren     <= 1'b0;
        r_m_dwen     <= 1'b0;
        r_m_halt     <= 1'b0;
      end
    end
  end

  // W slot: retire M on advance, bubble on a stall, freeze once a halt is in W
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_w_aluout   <= {WORD_W{1'b0}};
      r_w_dload    <= {WORD_W{1'b0}};
      r_w_npc      <= {WORD_W{1'b0}};
      r_w_wsel     <= {REG_W{1'b0}};
      r_w_regw     <= 1'b0;
      r_w_memtoreg <= 1'b0;
      r_w_halt     <= 1'b0;
    end else if (w_advance) begin
      r_w_aluout   <= r_m_aluout;
      r_w_dload    <= r_m_dren ? dload : {WORD_W{1'b0}};
      r_w_npc      <= r_m_npc;
      r_w_wsel     <= r_m_wsel;
      // a store never writes the register file, whatever EX claimed
      r_w_regw     <= r_m_regw & ~r_m_dwen;
      r_w_memtoreg <= r_m_memtoreg;
      r_w_halt     <= r_m_halt;
    end else if ((r_state != ST_HALTED) && !r_w_halt) begin
      r_w_aluout   <= {WORD_W{1'b0}};
      r_w_dload    <= {WORD_W{1'b0}};
      r_w_npc      <= {WORD_W{1'b0}};
      r_w_wsel     <= {REG_W{1'b0}};
      r_w_regw     <= 1'b0;
      r_w_memtoreg <= 1'b0;
      r_w_halt     <= 1'b0;
    end
  end

  assign aluout_o   = r_w_aluout;
  assign dload_o    = r_w_dload;
  assign npc_o      = r_w_npc;
  assign wsel_o     = r_w_wsel;
  assign RegW_o     = r_w_regw;
  assign MemToReg_o = r_w_memtoreg;
  assign halt_o     = r_w_halt;

endmodule

// File: tb/tb_exmem_stage.sv
// Testbench for exmem_stage: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_exmem_stage;

  logic        CLK = 1'b0;
  logic        nRST, flush, dhit;
  logic [31:0] aluout_i, rdat2_i, npc_i, dload;
  logic [4:0]  wsel_i;
  logic        RegW_i, MemToReg_i, DRen_i, DWen_i, halt_i;
  logic        dREN, dWEN, mem_stall;
  logic [31:0] daddr, dstore, aluout_o, dload_o, npc_o;
  logic [4:0]  wsel_o;
  logic        RegW_o, MemToReg_o, halt_o;

  always #5 CLK = ~CLK;

  exmem_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .aluout_i(aluout_i), .rdat2_i(rdat2_i), .npc_i(npc_i), .wsel_i(wsel_i),
    .RegW_i(RegW_i), .MemToReg_i(MemToReg_i), .DRen_i(DRen_i), .DWen_i(DWen_i),
    .halt_i(halt_i), .dhit(dhit), .dload(dload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .mem_stall(mem_stall), .aluout_o(aluout_o), .dload_o(dload_o),
    .npc_o(npc_o), .wsel_o(wsel_o), .RegW_o(RegW_o),
    .MemToReg_o(MemToReg_o), .halt_o(halt_o)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdat2;
    logic [31:0] npc;
    logic [4:0]  wsel;
    logic        regw;
    logic        m2r;
    logic        rd;
    logic        wr;
    logic        halt;
  } ins_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] npc;
    logic [4:0]  wsel;
    logic        regw;
    logic        m2r;
    logic        halt;
  } ret_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the instruction waiting in memory, the last retirement, frozen flag
  ins_t mdl_mem;
  ret_t mdl_ret;
  bit   mdl_frozen;
  bit   chk_en;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ins_t nop_ins();
    ins_t x;
    x = '0;
    return x;
  endfunction

  function automatic ins_t mk_ins(input logic [31:0] alu, input logic [31:0] st,
                                  input logic [4:0] ws, input bit regw, input bit m2r,
                                  input bit rd, input bit wr, input bit hl);
    ins_t x;
    x.alu = alu; x.rdat2 = st; x.npc = alu + 32'd4; x.wsel = ws;
    x.regw = regw; x.m2r = m2r; x.rd = rd; x.wr = wr; x.halt = hl;
    return x;
  endfunction

  function automatic ins_t rand_ins(input bit allow_halt);
    ins_t x;
    int   kind;
    x.alu = $urandom; x.rdat2 = $urandom; x.npc = $urandom;
    x.wsel = 5'($urandom_range(0, 31));
    x.regw = 1'($urandom_range(0, 1));
    x.m2r  = 1'($urandom_range(0, 1));
    kind   = $urandom_range(0, 3);
    x.rd   = (kind == 0);
    x.wr   = (kind == 1);
    x.halt = allow_halt && ($urandom_range(0, 99) == 0);
    return x;
  endfunction

  // Compare every DUT output with what the model says for the current cycle
  task automatic compare_all();
    bit pending;
    pending = !mdl_frozen && (mdl_mem.rd || mdl_mem.wr);
    check_val("dREN",       {31'd0, dREN},      {31'd0, !mdl_frozen && mdl_mem.rd});
    check_val("dWEN",       {31'd0, dWEN},      {31'd0, !mdl_frozen && mdl_mem.wr});
    check_val("mem_stall",  {31'd0, mem_stall}, {31'd0, pending && !dhit});
    check_val("daddr",      daddr,              mdl_mem.alu);
    check_val("dstore",     dstore,             mdl_mem.rdat2);
    check_val("aluout_o",   aluout_o,           mdl_ret.alu);
    check_val("dload_o",    dload_o,            mdl_ret.ld);
    check_val("npc_o",      npc_o,              mdl_ret.npc);
    check_val("wsel_o",     {27'd0, wsel_o},    {27'd0, mdl_ret.wsel});
    check_val("RegW_o",     {31'd0, RegW_o},    {31'd0, mdl_ret.regw});
    check_val("MemToReg_o", {31'd0, MemToReg_o},{31'd0, mdl_ret.m2r});
    check_val("halt_o",     {31'd0, halt_o},    {31'd0, mdl_ret.halt});
  endtask

  // What happens to the pipeline contents at a clock edge with the present inputs
  task automatic model_edge(input ins_t ins);
    ret_t r;
    if (!nRST) begin
      mdl_mem = '0; mdl_ret = '0; mdl_frozen = 1'b0;
    end else if (mdl_frozen) begin
      // nothing moves
    end else if (mdl_ret.halt) begin
      mdl_frozen = 1'b1;
    end else if ((mdl_mem.rd || mdl_mem.wr) && !dhit) begin
      mdl_ret = '0;
    end else begin
      r.alu  = mdl_mem.alu;
      r.ld   = mdl_mem.rd ? dload : 32'd0;
      r.npc  = mdl_mem.npc;
      r.wsel = mdl_mem.wsel;
      r.regw = mdl_mem.regw && !mdl_mem.wr;
      r.m2r  = mdl_mem.m2r;
      r.halt = mdl_mem.halt;
      mdl_ret = r;
      mdl_mem = (flush || mdl_mem.halt) ? nop_ins() : ins;
    end
  endtask

  // One clock: drive inputs, check at the falling edge, then step the model
  task automatic cycle(input ins_t ins, input bit fl, input bit hit,
                       input logic [31:0] ld, input bit rst_n);
    aluout_i = ins.alu; rdat2_i = ins.rdat2; npc_i = ins.npc; wsel_i = ins.wsel;
    RegW_i = ins.regw; MemToReg_i = ins.m2r; DRen_i = ins.rd; DWen_i = ins.wr;
    halt_i = ins.halt; flush = fl; dhit = hit; dload = ld; nRST = rst_n;
    #4;
    if (chk_en) compare_all();
    @(posedge CLK);
    model_edge(ins);
    chk_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(nop_ins(), 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    chk_en = 1'b0;
    mdl_mem = '0; mdl_ret = '0; mdl_frozen = 1'b0;
    nRST = 1'b0;
    @(posedge CLK);
    #1;

    // reset with random inputs for two edges
    for (int i = 0; i < 2; i++)
      cycle(rand_ins(1'b1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
    idle(1);

    // plain ALU op
    cycle(mk_ins(32'h0000_0010, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(nop_ins(), 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("alu_result", aluout_o, 32'h0000_0010);
    check_val("alu_wsel", {27'd0, wsel_o}, 32'd5);
    idle(2);

    // load, dhit in third M cycle
    cycle(mk_ins(32'h0000_0100, 32'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("ld_daddr", daddr, 32'h0000_0100);
    cycle(nop_ins(), 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(nop_ins(), 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("ld_bubble_regw", {31'd0, RegW_o}, 32'd0);
    cycle(nop_ins(), 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check_val("ld_data", dload_o, 32'hDEAD_BEEF);
    check_val("ld_regw", {31'd0, RegW_o}, 32'd1);
    idle(2);

    // store with immediate hit, EX claims RegW=1
    cycle(mk_ins(32'h0000_0200, 32'h1234_5678, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 1'b1, 32'd0, 1'b1);
    cycle(nop_ins(), 1'b0, 1'b1, 32'd0, 1'b1);
    check_val("st_regw_forced", {31'd0, RegW_o}, 32'd0);
    idle(2);

    // flush during RUN, then flush during WAIT
    cycle(mk_ins(32'h0000_0044, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 32'd0, 1'b1);
    cycle(nop_ins(), 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("flush_run_regw", {31'd0, RegW_o}, 32'd0);
    cycle(mk_ins(32'h0000_0300, 32'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(mk_ins(32'h0000_0055, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 32'd0, 1'b1);
    check_val("flush_wait_dren", {31'd0, dREN}, 32'd1);
    check_val("flush_wait_daddr", daddr, 32'h0000_0300);
    cycle(nop_ins(), 1'b0, 1'b1, 32'hCAFE_0001, 1'b1);
    idle(2);

    // halt followed by a load
    cycle(mk_ins(32'h0000_0070, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(mk_ins(32'h0000_0400, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(rand_ins(1'b0), 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b1);
    check_val("halt_sticky", {31'd0, halt_o}, 32'd1);
    check_val("halt_no_dren", {31'd0, dREN}, 32'd0);

    // reset pulse in the middle of an access
    cycle(nop_ins(), 1'b0, 1'b0, 32'd0, 1'b0);
    cycle(mk_ins(32'h0000_0500, 32'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(nop_ins(), 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(nop_ins(), 1'b0, 1'b0, 32'd0, 1'b0);
    check_val("rst_wait_dren", {31'd0, dREN}, 32'd0);
    cycle(mk_ins(32'h0000_0600, 32'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, 32'd0, 1'b1);
    cycle(nop_ins(), 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1);
    check_val("rst_then_load", dload_o, 32'h0BAD_F00D);

    // randomized traffic with occasional halts and resets
    for (int i = 0; i < 2000; i++)
      cycle(rand_ins(1'b1), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            $urandom, ($urandom_range(0, 39) != 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
